i2c_bkdr_port: RTL and testbench

I2C_BKDR_PORT -- requirements
Module: i2c_bkdr_port

---
 rtl/i2c_bkdr_port.sv | 171 +++++++++++++++++
 tb/tb_i2c_bkdr_port.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bkdr_port.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bkdr_port
// Description : Backdoor TX/RX FIFO access muxed over the functional I2C path,
//               plus a timed/held SDA override.
// Revision    : 1.0
// ============================================================================
module i2c_bkdr_port #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 2,
    parameter int HOLD_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bd_req,
    input  logic                       bd_wr,
    input  logic [2:0]                 bd_ch,
    input  logic [DATA_W-1:0]          bd_wdata,
    output logic                       bd_ack,
    output logic [DATA_W-1:0]          bd_rdata,
    output logic [1:0]                 bd_err,
    input  logic [NUM_CH-1:0]          fn_tx_push,
    input  logic [NUM_CH*DATA_W-1:0]   fn_tx_data,
    input  logic [NUM_CH-1:0]          fn_rx_pop,
    output logic [NUM_CH-1:0]          fn_stall,
    output logic [NUM_CH-1:0]          tx_push,
    output logic [NUM_CH*DATA_W-1:0]   tx_push_data,
    input  logic [NUM_CH-1:0]          tx_full,
    output logic [NUM_CH-1:0]          rx_pop,
    input  logic [NUM_CH*DATA_W-1:0]   rx_pop_data,
    input  logic [NUM_CH-1:0]          rx_empty,
    input  logic                       ovr_start,
    input  logic                       ovr_release,
    input  logic                       ovr_val,
    input  logic [HOLD_W-1:0]          ovr_cycles,
    output logic                       sda_ovr_oe,
    output logic                       sda_ovr_val,
    output logic                       ovr_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_wr;
    logic [DATA_W-1:0]   r_wdata;
    logic [NUM_CH-1:0]   r_stall;
    logic                r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_err;

    logic                r_ovr_oe;
    logic                r_ovr_val;
    logic [HOLD_W-1:0]   r_ovr_cnt;

    logic [NUM_CH-1:0]   w_req_sel;
    logic [NUM_CH-1:0]   w_bd_push;
    logic [NUM_CH-1:0]   w_bd_pop;
    logic                w_ch_ok;
    logic                w_fault;
    logic [DATA_W-1:0]   w_rd_mux;

    // r_stall is one-hot on the target channel for exactly the ACCESS cycle,
    // so it doubles as the per-channel backdoor select.
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_req_sel[i] = (bd_ch == 3'(i));
            assign w_bd_push[i] = r_stall[i] & r_wr & ~tx_full[i];
            assign w_bd_pop[i]  = r_stall[i] & ~r_wr & ~rx_empty[i];
            assign tx_push[i]   = r_stall[i] ? w_bd_push[i] : fn_tx_push[i];
            assign rx_pop[i]    = r_stall[i] ? w_bd_pop[i]  : fn_rx_pop[i];
            assign tx_push_data[i*DATA_W +: DATA_W] =
                r_stall[i] ? r_wdata : fn_tx_data[i*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_ch_ok = |r_stall;
    assign w_fault = |(r_stall & (r_wr ? tx_full : rx_empty));

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_stall[i]) begin
                w_rd_mux = w_rd_mux | rx_pop_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_stall <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_err   <= 2'b00;
        end else begin
            r_ack   <= 1'b0;
            r_stall <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bd_req) begin
                        r_wr    <= bd_wr;
                        r_wdata <= bd_wdata;
                        r_stall <= w_req_sel;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_ack   <= 1'b1;
                    r_state <= S_RESP;
                    if (!w_ch_ok) begin
                        r_err   <= 2'b10;
                        r_rdata <= '0;
                    end else if (w_fault) begin
                        r_err   <= 2'b01;
                        r_rdata <= '0;
                    end else begin
                        r_err   <= 2'b00;
                        r_rdata <= r_wr ? '0 : w_rd_mux;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A zero count means hold until released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovr_oe  <= 1'b0;
            r_ovr_val <= 1'b0;
            r_ovr_cnt <= '0;
        end else if (ovr_release) begin
            r_ovr_oe  <= 1'b0;
            r_ovr_val <= 1'b0;
            r_ovr_cnt <= '0;
        end else if (ovr_start) begin
            r_ovr_oe  <= 1'b1;
            r_ovr_val <= ovr_val;
            r_ovr_cnt <= ovr_cycles;
        end else if (r_ovr_oe && (r_ovr_cnt != '0)) begin
            if (r_ovr_cnt == HOLD_W'(1)) begin
                r_ovr_oe  <= 1'b0;
                r_ovr_val <= 1'b0;
                r_ovr_cnt <= '0;
            end else begin
                r_ovr_cnt <= r_ovr_cnt - HOLD_W'(1);
            end
        end
    end

    assign bd_ack      = r_ack;
    assign bd_rdata    = r_rdata;
    assign bd_err      = r_err;
    assign fn_stall    = r_stall;
    assign sda_ovr_oe  = r_ovr_oe;
    assign sda_ovr_val = r_ovr_val;
    assign ovr_busy    = r_ovr_oe;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bkdr_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_bkdr_port
// Description : Directed self-checking bench for i2c_bkdr_port.
// Revision    : 1.0
// ============================================================================
module tb_i2c_bkdr_port;

    localparam int DATA_W = 8;
    localparam int NUM_CH = 2;
    localparam int HOLD_W = 16;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      bd_req;
    logic                      bd_wr;
    logic [2:0]                bd_ch;
    logic [DATA_W-1:0]         bd_wdata;
    logic                      bd_ack;
    logic [DATA_W-1:0]         bd_rdata;
    logic [1:0]                bd_err;
    logic [NUM_CH-1:0]         fn_tx_push;
    logic [NUM_CH*DATA_W-1:0]  fn_tx_data;
    logic [NUM_CH-1:0]         fn_rx_pop;
    logic [NUM_CH-1:0]         fn_stall;
    logic [NUM_CH-1:0]         tx_push;
    logic [NUM_CH*DATA_W-1:0]  tx_push_data;
    logic [NUM_CH-1:0]         tx_full;
    logic [NUM_CH-1:0]         rx_pop;
    logic [NUM_CH*DATA_W-1:0]  rx_pop_data;
    logic [NUM_CH-1:0]         rx_empty;
    logic                      ovr_start;
    logic                      ovr_release;
    logic                      ovr_val;
    logic [HOLD_W-1:0]         ovr_cycles;
    logic                      sda_ovr_oe;
    logic                      sda_ovr_val;
    logic                      ovr_busy;

    int checks = 0;
    int errors = 0;

    i2c_bkdr_port #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .HOLD_W(HOLD_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bd_req       (bd_req),
        .bd_wr        (bd_wr),
        .bd_ch        (bd_ch),
        .bd_wdata     (bd_wdata),
        .bd_ack       (bd_ack),
        .bd_rdata     (bd_rdata),
        .bd_err       (bd_err),
        .fn_tx_push   (fn_tx_push),
        .fn_tx_data   (fn_tx_data),
        .fn_rx_pop    (fn_rx_pop),
        .fn_stall     (fn_stall),
        .tx_push      (tx_push),
        .tx_push_data (tx_push_data),
        .tx_full      (tx_full),
        .rx_pop       (rx_pop),
        .rx_pop_data  (rx_pop_data),
        .rx_empty     (rx_empty),
        .ovr_start    (ovr_start),
        .ovr_release  (ovr_release),
        .ovr_val      (ovr_val),
        .ovr_cycles   (ovr_cycles),
        .sda_ovr_oe   (sda_ovr_oe),
        .sda_ovr_val  (sda_ovr_val),
        .ovr_busy     (ovr_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({bd_ack, bd_rdata, bd_err, fn_stall} !== 13'd0) begin
            errors++;
            $display("FAIL reset_bd: got ack=%b rdata=%h err=%b stall=%b, want all 0",
                     bd_ack, bd_rdata, bd_err, fn_stall);
        end
        checks++;
        if ({sda_ovr_oe, sda_ovr_val, ovr_busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ovr: got oe=%b val=%b busy=%b, want 000",
                     sda_ovr_oe, sda_ovr_val, ovr_busy);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        tx_full = 2'b00; bd_wr = 1'b1; bd_ch = 3'd1; bd_wdata = 8'hA5; bd_req = 1'b1;
        tick();
        checks++;
        if (tx_push !== 2'b10 || tx_push_data[15:8] !== 8'hA5) begin
            errors++;
            $display("FAIL wr_push: got push=%b data=%h, want 10 a5", tx_push, tx_push_data[15:8]);
        end
        checks++;
        if (fn_stall !== 2'b10 || bd_ack !== 1'b0) begin
            errors++;
            $display("FAIL wr_stall_c1: got stall=%b ack=%b, want 10 0", fn_stall, bd_ack);
        end
        tick();
        bd_req = 1'b0;
        checks++;
        if (bd_ack !== 1'b1 || bd_err !== 2'b00 || bd_rdata !== 8'h00) begin
            errors++;
            $display("FAIL wr_ack: got ack=%b err=%b rdata=%h, want 1 00 00", bd_ack, bd_err, bd_rdata);
        end
        checks++;
        if (fn_stall !== 2'b00 || tx_push !== 2'b00) begin
            errors++;
            $display("FAIL wr_c2_quiet: got stall=%b push=%b, want 00 00", fn_stall, tx_push);
        end
        tick();
        checks++;
        if (bd_ack !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack_pulse: got ack=%b, want 0", bd_ack);
        end
    endtask

    task automatic test_read();
        rx_empty = 2'b00; rx_pop_data = {8'h77, 8'h3C};
        bd_wr = 1'b0; bd_ch = 3'd0; bd_req = 1'b1;
        tick();
        checks++;
        if (rx_pop !== 2'b01 || fn_stall !== 2'b01) begin
            errors++;
            $display("FAIL rd_pop: got pop=%b stall=%b, want 01 01", rx_pop, fn_stall);
        end
        tick();
        bd_req = 1'b0;
        checks++;
        if (bd_ack !== 1'b1 || bd_rdata !== 8'h3C || bd_err !== 2'b00) begin
            errors++;
            $display("FAIL rd_data: got ack=%b rdata=%h err=%b, want 1 3c 00", bd_ack, bd_rdata, bd_err);
        end
        tick();
        rx_empty = 2'b01; bd_req = 1'b1;
        tick();
        checks++;
        if (rx_pop !== 2'b00) begin
            errors++;
            $display("FAIL rd_empty_pop: got pop=%b, want 00", rx_pop);
        end
        tick();
        bd_req = 1'b0;
        checks++;
        if (bd_ack !== 1'b1 || bd_err !== 2'b01 || bd_rdata !== 8'h00) begin
            errors++;
            $display("FAIL rd_empty_err: got ack=%b err=%b rdata=%h, want 1 01 00", bd_ack, bd_err, bd_rdata);
        end
        rx_empty = 2'b00;
        tick();
    endtask

    task automatic test_bad_channel();
        fn_tx_push = 2'b01; fn_tx_data = {8'h00, 8'h5A};
        bd_wr = 1'b1; bd_ch = 3'd5; bd_wdata = 8'hEE; bd_req = 1'b1;
        tick();
        checks++;
        if (fn_stall !== 2'b00 || tx_push !== 2'b01 || tx_push_data[7:0] !== 8'h5A || rx_pop !== 2'b00) begin
            errors++;
            $display("FAIL badch_pass: got stall=%b push=%b data=%h pop=%b, want 00 01 5a 00",
                     fn_stall, tx_push, tx_push_data[7:0], rx_pop);
        end
        tick();
        bd_req = 1'b0;
        checks++;
        if (bd_ack !== 1'b1 || bd_err !== 2'b10 || bd_rdata !== 8'h00) begin
            errors++;
            $display("FAIL badch_err: got ack=%b err=%b rdata=%h, want 1 10 00", bd_ack, bd_err, bd_rdata);
        end
        fn_tx_push = 2'b00;
        tick();
    endtask

    task automatic test_suppress_full();
        fn_tx_push = 2'b11; fn_tx_data = {8'hC3, 8'h11}; tx_full = 2'b01;
        bd_wr = 1'b1; bd_ch = 3'd0; bd_wdata = 8'h99; bd_req = 1'b1;
        tick();
        checks++;
        if (tx_push !== 2'b10 || tx_push_data[15:8] !== 8'hC3) begin
            errors++;
            $display("FAIL supp_push: got push=%b data1=%h, want 10 c3", tx_push, tx_push_data[15:8]);
        end
        tick();
        bd_req = 1'b0;
        checks++;
        if (bd_ack !== 1'b1 || bd_err !== 2'b01) begin
            errors++;
            $display("FAIL supp_err: got ack=%b err=%b, want 1 01", bd_ack, bd_err);
        end
        checks++;
        if (tx_push !== 2'b11) begin
            errors++;
            $display("FAIL supp_resume: got push=%b, want 11", tx_push);
        end
        fn_tx_push = 2'b00; tx_full = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        bd_wr = 1'b1; bd_ch = 3'd0; bd_wdata = 8'h10; bd_req = 1'b1;
        tick();
        checks++;
        if (tx_push !== 2'b01 || tx_push_data[7:0] !== 8'h10) begin
            errors++;
            $display("FAIL b2b_first: got push=%b data0=%h, want 01 10", tx_push, tx_push_data[7:0]);
        end
        tick();
        bd_ch = 3'd1; bd_wdata = 8'h20;
        checks++;
        if (bd_ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ack1: got ack=%b, want 1", bd_ack);
        end
        tick();
        checks++;
        if (bd_ack !== 1'b0 || tx_push !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle: got ack=%b push=%b, want 0 00", bd_ack, tx_push);
        end
        tick();
        checks++;
        if (tx_push !== 2'b10 || tx_push_data[15:8] !== 8'h20 || fn_stall !== 2'b10) begin
            errors++;
            $display("FAIL b2b_second: got push=%b data1=%h stall=%b, want 10 20 10",
                     tx_push, tx_push_data[15:8], fn_stall);
        end
        tick();
        bd_req = 1'b0;
        checks++;
        if (bd_ack !== 1'b1 || bd_err !== 2'b00) begin
            errors++;
            $display("FAIL b2b_ack2: got ack=%b err=%b, want 1 00", bd_ack, bd_err);
        end
        tick();
    endtask

    task automatic test_ovr_count();
        int highs;
        ovr_start = 1'b1; ovr_val = 1'b0; ovr_cycles = 16'd4;
        tick();
        ovr_start = 1'b0;
        checks++;
        if (sda_ovr_oe !== 1'b1 || sda_ovr_val !== 1'b0 || ovr_busy !== 1'b1) begin
            errors++;
            $display("FAIL ovr4_start: got oe=%b val=%b busy=%b, want 1 0 1", sda_ovr_oe, sda_ovr_val, ovr_busy);
        end
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            if (sda_ovr_oe === 1'b1) highs++;
            tick();
        end
        checks++;
        if (highs != 4) begin
            errors++;
            $display("FAIL ovr4_len: got %0d cycles, want 4", highs);
        end
        // restart after two cycles of a 4-cycle override
        ovr_start = 1'b1; ovr_val = 1'b0; ovr_cycles = 16'd4;
        tick();
        ovr_start = 1'b0;
        tick();
        ovr_start = 1'b1; ovr_val = 1'b1; ovr_cycles = 16'd3;
        tick();
        ovr_start = 1'b0;
        checks++;
        if (sda_ovr_oe !== 1'b1 || sda_ovr_val !== 1'b1) begin
            errors++;
            $display("FAIL ovr_restart_val: got oe=%b val=%b, want 1 1", sda_ovr_oe, sda_ovr_val);
        end
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            if (sda_ovr_oe === 1'b1) highs++;
            tick();
        end
        checks++;
        if (highs != 3) begin
            errors++;
            $display("FAIL ovr_restart_len: got %0d cycles, want 3", highs);
        end
    endtask

    task automatic test_ovr_hold();
        ovr_start = 1'b1; ovr_val = 1'b1; ovr_cycles = 16'd0;
        tick();
        ovr_start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        checks++;
        if (sda_ovr_oe !== 1'b1 || sda_ovr_val !== 1'b1) begin
            errors++;
            $display("FAIL ovr_hold: got oe=%b val=%b, want 1 1", sda_ovr_oe, sda_ovr_val);
        end
        ovr_release = 1'b1;
        tick();
        ovr_release = 1'b0;
        checks++;
        if (sda_ovr_oe !== 1'b0 || ovr_busy !== 1'b0) begin
            errors++;
            $display("FAIL ovr_release: got oe=%b busy=%b, want 0 0", sda_ovr_oe, ovr_busy);
        end
        ovr_start = 1'b1; ovr_cycles = 16'd0;
        tick();
        ovr_start = 1'b1; ovr_release = 1'b1; ovr_cycles = 16'd5;
        tick();
        ovr_start = 1'b0; ovr_release = 1'b0;
        checks++;
        if (sda_ovr_oe !== 1'b0) begin
            errors++;
            $display("FAIL ovr_rel_prio: got oe=%b, want 0", sda_ovr_oe);
        end
    endtask

    task automatic test_reset_mid_access();
        ovr_start = 1'b1; ovr_val = 1'b1; ovr_cycles = 16'd0;
        bd_wr = 1'b1; bd_ch = 3'd1; bd_wdata = 8'h5C; bd_req = 1'b1;
        tick();
        ovr_start = 1'b0;
        checks++;
        if (fn_stall !== 2'b10 || tx_push !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_access: got stall=%b push=%b, want 10 10", fn_stall, tx_push);
        end
        rst_n = 1'b0;
        tick();
        bd_req = 1'b0;
        checks++;
        if ({bd_ack, bd_err, fn_stall, tx_push, rx_pop, sda_ovr_oe, sda_ovr_val, ovr_busy} !== 12'd0) begin
            errors++;
            $display("FAIL rstmid_clear: got ack=%b err=%b stall=%b push=%b pop=%b oe=%b val=%b busy=%b, want all 0",
                     bd_ack, bd_err, fn_stall, tx_push, rx_pop, sda_ovr_oe, sda_ovr_val, ovr_busy);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bd_ack !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_noack: got ack=%b, want 0", bd_ack);
        end
        fn_tx_push = 2'b10; fn_tx_data = {8'h6B, 8'h00}; fn_rx_pop = 2'b01;
        #1;
        checks++;
        if (tx_push !== 2'b10 || tx_push_data[15:8] !== 8'h6B || rx_pop !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_pass: got push=%b data1=%h pop=%b, want 10 6b 01",
                     tx_push, tx_push_data[15:8], rx_pop);
        end
        fn_tx_push = 2'b00; fn_rx_pop = 2'b00;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; bd_req = 1'b0; bd_wr = 1'b0; bd_ch = 3'd0; bd_wdata = '0;
        fn_tx_push = '0; fn_tx_data = '0; fn_rx_pop = '0;
        tx_full = '0; rx_pop_data = '0; rx_empty = '0;
        ovr_start = 1'b0; ovr_release = 1'b0; ovr_val = 1'b0; ovr_cycles = '0;
        test_reset();
        test_write();
        test_read();
        test_bad_channel();
        test_suppress_full();
        test_back_to_back();
        test_ovr_count();
        test_ovr_hold();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
